// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and controller states.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDSUB,
    ST_MUL,
    ST_DIV,
    ST_FIN
  } alu_state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per cycle
// on a shared 2*width register ({acc, mplier} for mul, {rem, quot} for div).
module alu_iter_unit #(
  parameter int width = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [2*width-1:0] acc,
  output logic               count_zero
);

  localparam int CW = $clog2(width + 1);

  logic [CW-1:0]      count;
  logic [2*width-1:0] acc_r;
  logic [width:0]     mul_sum;
  logic [width:0]     rem_shift;
  logic [width:0]     rem_diff;
  logic               ge;

  always_comb begin
    mul_sum   = {1'b0, acc_r[2*width-1:width]} + (acc_r[0] ? {1'b0, b} : {(width+1){1'b0}});
    rem_shift = {acc_r[2*width-1:width], acc_r[width-1]};
    ge        = (rem_shift >= {1'b0, b});
    rem_diff  = ge ? (rem_shift - {1'b0, b}) : rem_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(width);
    end else if (step) begin
      count <= count - 1'b1;
    end
  end

  // The remainder always stays below b, so its low width bits are the whole value.
  always_ff @(posedge clk) begin
    if (load) begin
      acc_r <= {{width{1'b0}}, a};
    end else if (step) begin
      acc_r <= div_mode ? {rem_diff[width-1:0], acc_r[width-2:0], ge}
                        : {mul_sum, acc_r[width-1:1]};
    end
  end

  assign acc        = acc_r;
  assign count_zero = (count == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: add/sub in one step, iterative mul/div, registered
// result with carry/borrow and divide-by-zero flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int width = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  input  logic [1:0]         func,
  output logic               busy,
  output logic               done,
  output logic [2*width-1:0] out,
  output logic               ovf,
  output logic               dbz
);

  alu_state_t         state, state_next;
  logic [width-1:0]   a_q, b_q;
  logic [1:0]         func_q;
  logic [width:0]     addsub_q;
  logic               load, step, count_zero, div_zero;
  logic [2*width-1:0] acc;
  logic [2*width-1:0] fin_out;
  logic               fin_ovf, fin_dbz;

  assign div_zero = (b_q == '0);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (!func[1])              state_next = ST_ADDSUB;
          else if (func == ALU_MUL)  state_next = ST_MUL;
          else                       state_next = ST_DIV;
        end
      end
      ST_ADDSUB: state_next = ST_FIN;
      ST_MUL: begin
        if (count_zero) state_next = ST_FIN;
        else            step = 1'b1;
      end
      ST_DIV: begin
        if (div_zero || count_zero) state_next = ST_FIN;
        else                        step = 1'b1;
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands are captured once so the requester may change them freely afterwards.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q    <= a;
      b_q    <= b;
      func_q <= func;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_ADDSUB) begin
      addsub_q <= (func_q == ALU_SUB) ? ({1'b0, a_q} - {1'b0, b_q})
                                      : ({1'b0, a_q} + {1'b0, b_q});
    end
  end

  alu_iter_unit #(.width(width)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .div_mode   (func_q == ALU_DIV),
    .a          (a),
    .b          (b_q),
    .acc        (acc),
    .count_zero (count_zero)
  );

  always_comb begin
    fin_out = acc;
    fin_ovf = 1'b0;
    fin_dbz = 1'b0;
    case (func_q)
      ALU_ADD, ALU_SUB: begin
        fin_out = {{width{1'b0}}, addsub_q[width-1:0]};
        fin_ovf = addsub_q[width];
      end
      ALU_DIV: begin
        if (div_zero) begin
          fin_out = {{width{1'b1}}, a_q};
          fin_dbz = 1'b1;
        end else begin
          fin_out = {acc[width-1:0], acc[2*width-1:width]};
        end
      end
      default: fin_out = acc;
    endcase
  end

  // done is raised on the edge that returns to IDLE, so it never overlaps busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      out  <= '0;
      ovf  <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      done <= (state == ST_FIN);
      if (state == ST_FIN) begin
        out <= fin_out;
        ovf <= fin_ovf;
        dbz <= fin_dbz;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model results, a monitor checks each done.
module tb_alu_seq;

  localparam int W = 6;
  localparam int M = 1 << W;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [W-1:0]   a, b;
  logic [1:0]     func;
  logic           busy, done, ovf, dbz;
  logic [2*W-1:0] out;

  alu_seq #(.width(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .func(func),
    .busy(busy), .done(done), .out(out), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] out;
    logic           ovf;
    logic           dbz;
    int             due;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  logic [2*W-1:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic on the operation rules; acc is the accepting edge.
  function automatic exp_t model(input int f, input int x, input int y, input int acc);
    exp_t e;
    int   v;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    v     = 0;
    case (f)
      0: begin v = (x + y) % M; e.ovf = ((x + y) >= M); e.due = acc + 2; end
      1: begin v = (x - y + M) % M; e.ovf = (x < y); e.due = acc + 2; end
      2: begin v = x * y; e.due = acc + W + 2; end
      default: begin
        if (y == 0) begin
          v = ((M - 1) * M) + x; e.dbz = 1'b1; e.due = acc + 2;
        end else begin
          v = (x / y) * M + (x % y); e.due = acc + W + 2;
        end
      end
    endcase
    e.out = v[2*W-1:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", 32'(out), 32'(e.out));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("dbz", 32'(dbz), 32'(e.dbz));
        check("done_edge", 32'(cyc), 32'(e.due));
        check("busy_at_done", 32'(busy), 32'd0);
        held = e.out;
      end
    end
  end

  task automatic issue(input int f, input int x, input int y);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      failures++;
      $display("FAIL busy_timeout actual=1 required=0");
    end
    start = 1'b1;
    a     = W'(x);
    b     = W'(y);
    func  = 2'(f);
    sb.push_back(model(f, x, y, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    func  = 2'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL done_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; func = '0;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_out", 32'(out), 0);
    check("rst_flags", {30'd0, ovf, dbz}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    issue(0, 50, 20); drain();
    issue(0, 3, 4);   drain();
    issue(1, 5, 9);   drain();
    issue(1, 9, 5);   drain();
    issue(3, 45, 7);  drain();
    issue(3, 13, 0);  drain();

    // Mul with an ignored start pulse in the middle.
    issue(2, 63, 63);
    @(negedge clk);
    check("busy_mid_mul", 32'(busy), 1);
    check("out_held_mid_mul", 32'(out), 32'(held));
    start = 1'b1; a = 6'd1; b = 6'd1; func = 2'b00;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("out_after_ignored_start", 32'(out), 32'hF81);

    // start held high through done: second op accepted in the done cycle.
    @(negedge clk);
    start = 1'b1; a = 6'd10; b = 6'd20; func = 2'b00;
    sb.push_back(model(0, 10, 20, cyc + 1));
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_start_done_seen", 32'(done), 1);
    a = 6'd40; b = 6'd30; func = 2'b01;
    sb.push_back(model(1, 40, 30, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset part-way through a mul.
    issue(2, 50, 40);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_out", 32'(out), 0);
    check("abort_flags", {30'd0, ovf, dbz}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("out_after_abort", 32'(out), 0);
    issue(0, 1, 1); drain();

    // Randomized traffic; consecutive issues land back-to-back on done cycles.
    for (int i = 0; i < 40; i++) begin
      int f, x, y;
      f = $urandom_range(0, 3);
      x = $urandom_range(0, M - 1);
      y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, M - 1);
      issue(f, x, y);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
